// File: rtl/logic_sequencer.sv
// logic_sequencer
//   Sequences a single request through an external combinational logic unit.
//   Non-shift ops take one pass. Shift ops take one pass per shift bit,
//   because the unit shifts by exactly one bit per pass. The result is then
//   held until the consumer accepts it.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ReqValid/ReqReady   request handshake (ReqReady only in IDLE, out of reset)
//   ReqA, ReqB          32-bit operands
//   ReqOp               000 AND, 001 OR, 010 XOR, 011 LSL, 100 LSR,
//                       101 ASL, 110 ASR, 111 zero
//   ReqShamt            shift amount, used by ops 011-110 only
//   LogicA/B/Op         registered operands and opcode sent to the logic unit
//   LogicAnswer         combinational result returned by the logic unit
//   RespValid/RespReady response handshake
//   RespData            result (always the accumulator)
//   Busy                high whenever the sequencer is not IDLE
module logic_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqA,
    input  logic [31:0] ReqB,
    input  logic [2:0]  ReqOp,
    input  logic [4:0]  ReqShamt,
    output logic [31:0] LogicA,
    output logic [31:0] LogicB,
    output logic [2:0]  LogicOp,
    input  logic [31:0] LogicAnswer,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespData,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q,   acc_d;
    logic [31:0] br_q,    br_d;
    logic [2:0]  opr_q,   opr_d;
    logic [4:0]  count_q, count_d;

    logic req_is_shift;

    assign req_is_shift = (ReqOp >= 3'b011) && (ReqOp <= 3'b110);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            br_q    <= '0;
            opr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            br_q    <= br_d;
            opr_q   <= opr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        br_d    = br_q;
        opr_d   = opr_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    acc_d   = ReqA;
                    br_d    = ReqB;
                    opr_d   = ReqOp;
                    count_d = req_is_shift ? ReqShamt : 5'd1;
                    // A zero-length shift is already complete: the operand is the answer.
                    if (req_is_shift && (ReqShamt == 5'd0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d   = LogicAnswer;
                count_d = count_q - 5'd1;
                // Count is never 0 in RUN; treating <=1 as last pass keeps it from wrapping.
                if (count_q <= 5'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (RespReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ReqReady is gated by reset so it is low while reset is held.
    assign ReqReady  = (state_q == IDLE) && !reset;
    assign RespValid = (state_q == DONE);
    assign RespData  = acc_q;
    assign Busy      = (state_q != IDLE);
    assign LogicA    = acc_q;
    assign LogicB    = br_q;
    assign LogicOp   = opr_q;

endmodule
